// File: rtl/interrupt_pkg.sv
// Shared types and constants for the Synapse interrupt controller.
package interrupt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam int VECTOR_WIDTH = 16;

endpackage

// File: rtl/priority_encoder.sv
// Peripheral priority encoder: returns the index of the lowest set request bit.
module priority_encoder
  import interrupt_pkg::*;
#(
  parameter int NUM_INPUTS = 16
) (
  input  logic [NUM_INPUTS-1:0]   req,
  output logic [VECTOR_WIDTH-1:0] out
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    out = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      if (req[i]) out = VECTOR_WIDTH'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latching, maskable interrupt controller with req/ack/eoi handshake to the CPU.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int TOP_INPUT  = NUM_INPUTS - 1
) (
  input  logic                    sysclk,
  input  logic                    sysreset_n,
  input  logic [TOP_INPUT:0]      irq_in,
  input  logic                    mask_wr,
  input  logic [TOP_INPUT:0]      mask_wdata,
  output logic [TOP_INPUT:0]      mask_out,
  output logic [TOP_INPUT:0]      pending_out,
  output logic                    irq_req,
  output logic [VECTOR_WIDTH-1:0] irq_vector,
  input  logic                    irq_ack,
  input  logic                    irq_eoi,
  output logic                    in_service
);

  irq_state_t              state, state_n;
  logic [TOP_INPUT:0]      prev_in, pending, mask;
  logic [TOP_INPUT:0]      eligible, edges, clr;
  logic [VECTOR_WIDTH-1:0] winner;
  logic                    any_eligible, load_vec, take_ack;

  assign edges        = irq_in & ~prev_in;
  assign eligible     = pending & mask;
  assign any_eligible = |eligible;

  priority_encoder #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_enc (
    .req (eligible),
    .out (winner)
  );

  always_comb begin
    state_n  = state;
    load_vec = 1'b0;
    take_ack = 1'b0;
    case (state)
      IDLE: begin
        if (any_eligible) begin
          state_n  = REQUEST;
          load_vec = 1'b1;
        end
      end
      REQUEST: begin
        if (irq_ack) begin
          state_n  = SERVICE;
          take_ack = 1'b1;
        end
      end
      SERVICE: begin
        if (irq_eoi) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Decode the offered vector into a one-hot clear; a same-cycle new edge overrides it.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      clr[i] = take_ack && (irq_vector == VECTOR_WIDTH'(i));
    end
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state      <= IDLE;
      prev_in    <= '0;
      pending    <= '0;
      mask       <= '0;
      irq_vector <= '0;
      irq_req    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      state      <= state_n;
      prev_in    <= irq_in;
      pending    <= (pending & ~clr) | edges;
      irq_req    <= (state_n == REQUEST);
      in_service <= (state_n == SERVICE);
      if (mask_wr)  mask       <= mask_wdata;
      if (load_vec) irq_vector <= winner;
    end
  end

  assign mask_out    = mask;
  assign pending_out = pending;

endmodule
